if_fetch_unit: RTL and testbench

Instruction-fetch stage that produces the IF-side bundle (`if_valid`, `if_inst`, `if_pc`, `if_pc4`) for the IF/ID pipeline register. It owns the PC and issues requests to instruction memory over a request/response handshake with one request outstanding. A one-entry skid buffer absorbs responses that arrive while `pipeline_stop` is asserted. It obeys the same `pipeline_stop` / `control_hazard` controls as the IF/ID register; `control_hazard` redirects fetch to `redirect_pc`.

---
 rtl/if_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, presents the IF/ID bundle.
// Optional one-entry skid buffer for responses landing during a stall: define FETCH_SKID_EN.
//
// state | meaning
// FETCH | request imem at pc
// WAIT  | response for pc_inflight still owed
// HOLD  | issue blocked by downstream backpressure
// DROP  | response owed after a redirect, discarded on arrival

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_stop,
    input  logic        control_hazard,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pc_inflight;
    logic        r_if_valid;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc4;

    logic        w_rsp;
    logic        w_issue_ok;
    logic        w_req;
    logic        w_blocked_nxt;
    logic        w_if_valid_nxt;
    logic        w_out_load;
    logic [31:0] w_out_inst;
    logic [31:0] w_out_pc;
    logic [31:0] w_redirect_aligned;

`ifdef FETCH_SKID_EN
    logic        r_sk_valid;
    logic [31:0] r_sk_inst;
    logic [31:0] r_sk_pc;
    logic        w_sk_valid_nxt;
    logic        w_sk_load;
    logic        w_out_from_sk;
`endif

    assign w_rsp              = (r_state == S_WAIT) && imem_rvalid;
    assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_SKID_EN
    assign w_issue_ok = !r_sk_valid;
`else
    assign w_issue_ok = !(r_if_valid && pipeline_stop);
`endif

    // Where the next output/skid contents come from; redirect overrides in the register block.
    always_comb begin
        w_if_valid_nxt = r_if_valid;
        w_out_load     = 1'b0;
        w_out_inst     = imem_rdata;
        w_out_pc       = r_pc_inflight;
`ifdef FETCH_SKID_EN
        w_sk_valid_nxt = r_sk_valid;
        w_sk_load      = 1'b0;
        w_out_from_sk  = 1'b0;
        if (!pipeline_stop) begin
            if (r_sk_valid) begin
                w_if_valid_nxt = 1'b1;
                w_out_load     = 1'b1;
                w_out_from_sk  = 1'b1;
                w_sk_valid_nxt = w_rsp;
                w_sk_load      = w_rsp;
            end else begin
                w_if_valid_nxt = w_rsp;
                w_out_load     = w_rsp;
            end
        end else if (w_rsp) begin
            if (!r_if_valid) begin
                w_if_valid_nxt = 1'b1;
                w_out_load     = 1'b1;
            end else begin
                w_sk_valid_nxt = 1'b1;
                w_sk_load      = 1'b1;
            end
        end
        if (w_out_from_sk) begin
            w_out_inst = r_sk_inst;
            w_out_pc   = r_sk_pc;
        end
        w_blocked_nxt = w_sk_valid_nxt;
`else
        if (w_rsp) begin
            w_if_valid_nxt = 1'b1;
            w_out_load     = 1'b1;
        end else if (!pipeline_stop) begin
            w_if_valid_nxt = 1'b0;
        end
        w_blocked_nxt = w_if_valid_nxt && pipeline_stop;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_issue_ok) begin
                    w_req = 1'b1;
                    if (imem_ready) w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_WAIT:  if (imem_rvalid) w_state_nxt = w_blocked_nxt ? S_HOLD : S_FETCH;
            S_HOLD:  if (w_issue_ok) w_state_nxt = S_FETCH;
            S_DROP:  if (imem_rvalid) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
        // A request still owed after this edge must be drained before the new pc is fetched.
        if (control_hazard) begin
            if (((r_state == S_WAIT || r_state == S_DROP) && !imem_rvalid) || (w_req && imem_ready))
                w_state_nxt = S_DROP;
            else
                w_state_nxt = S_FETCH;
        end
    end

    assign imem_req  = w_req && !rst;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_inst   = r_if_inst;
    assign if_pc     = r_if_pc;
    assign if_pc4    = r_if_pc4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_pc_inflight <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_inst     <= 32'h0;
            r_if_pc       <= 32'h0;
            r_if_pc4      <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req && imem_ready) r_pc_inflight <= r_pc;
            if (control_hazard)      r_pc <= w_redirect_aligned;
            else if (w_rsp)          r_pc <= r_pc_inflight + 32'd4;
            r_if_valid <= w_if_valid_nxt && !control_hazard;
            if (w_out_load && !control_hazard) begin
                r_if_inst <= w_out_inst;
                r_if_pc   <= w_out_pc;
                r_if_pc4  <= w_out_pc + 32'd4;
            end
        end
    end

`ifdef FETCH_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sk_valid <= 1'b0;
            r_sk_inst  <= 32'h0;
            r_sk_pc    <= 32'h0;
        end else begin
            r_sk_valid <= w_sk_valid_nxt && !control_hazard;
            if (w_sk_load && !control_hazard) begin
                r_sk_inst <= imem_rdata;
                r_sk_pc   <= r_pc_inflight;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: fetch order, stalls, redirects, wrap and mid-operation reset.
// Expectations follow the FETCH_SKID_EN setting of the build.

module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipeline_stop, control_hazard;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst, if_pc, if_pc4;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .pipeline_stop(pipeline_stop), .control_hazard(control_hazard), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4)
    );

`ifdef FETCH_SKID_EN
    localparam logic [31:0] EXP_SKID = 32'd1;
`else
    localparam logic [31:0] EXP_SKID = 32'd0;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic        stop_v = 1'b0, haz_v = 1'b0, rdy_v = 1'b1, rst_v = 1'b1;
    logic [31:0] rpc_v = 32'h0;
    int          mem_lat = 1;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        req_s;
    logic [31:0] addr_s;
    logic [31:0] consumed[$];
    logic [31:0] acc_q[$];
    int          acc0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs and memory response at negedge, sample comb outputs, log traffic.
    task automatic cycle();
        @(negedge clk);
        rst            = rst_v;
        pipeline_stop  = stop_v;
        control_hazard = haz_v;
        redirect_pc    = rpc_v;
        imem_ready     = rdy_v;
        imem_rvalid    = 1'b0;
        if (mem_pend) begin
            if (mem_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = inst_of(mem_addr);
                mem_pend    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
        req_s  = imem_req;
        addr_s = imem_addr;
        if (imem_req && imem_ready) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
            acc_q.push_back(imem_addr);
        end
        if (if_valid && !pipeline_stop && !control_hazard) begin
            consumed.push_back(if_pc);
            check_val("inst", if_inst, inst_of(if_pc));
        end
    endtask

    task automatic wait_consume(input string tag, input logic [31:0] exp_pc);
        int n0;
        n0 = consumed.size();
        for (int i = 0; i < 20 && consumed.size() == n0; i++) cycle();
        check_val({tag, "_seen"}, consumed.size() - n0, 32'd1);
        if (consumed.size() > n0) begin
            check_val({tag, "_pc"}, consumed[n0], exp_pc);
            check_val({tag, "_pc4"}, if_pc4, exp_pc + 32'd4);
        end
    endtask

    initial begin
        pipeline_stop = 1'b0; control_hazard = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        cycle(); cycle();
        check_val("rst_req", req_s, 32'd0);
        check_val("rst_addr", addr_s, 32'h0);
        check_val("rst_valid", if_valid, 32'd0);
        check_val("rst_pc", if_pc, 32'h0);
        check_val("rst_pc4", if_pc4, 32'h0);
        check_val("rst_inst", if_inst, 32'h0);

        // sequential fetch, k=1
        rst_v = 1'b0;
        cycle();
        check_val("start_req", req_s, 32'd1);
        check_val("start_addr", addr_s, 32'h0);
        cycle();
        check_val("wait_req", req_s, 32'd0);
        cycle();
        check_val("seq_valid", if_valid, 32'd1);
        check_val("seq_pc", if_pc, 32'h0);
        check_val("seq_pc4", if_pc4, 32'h4);
        check_val("seq_addr", addr_s, 32'h4);
        cycle();

        // stall while 0x4 is on the output
        stop_v = 1'b1;
        acc0 = acc_q.size();
        cycle();
        check_val("stall_pc", if_pc, 32'h4);
        check_val("stall_pc4", if_pc4, 32'h8);
        check_val("stall_issue", req_s, EXP_SKID);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_val("stall_hold_valid", if_valid, 32'd1);
            check_val("stall_hold_pc", if_pc, 32'h4);
            if (i > 0) check_val("stall_no_req", req_s, 32'd0);
        end
        check_val("stall_accepts", acc_q.size() - acc0, EXP_SKID);
        mem_lat = 3;
        stop_v  = 1'b0;
        for (int i = 0; i < 30 && consumed.size() < 4; i++) cycle();
        check_val("order_n", consumed.size(), 32'd4);
        if (consumed.size() >= 4) begin
            check_val("order_0", consumed[0], 32'h0);
            check_val("order_1", consumed[1], 32'h4);
            check_val("order_2", consumed[2], 32'h8);
            check_val("order_3", consumed[3], 32'hC);
        end

        // redirect while 0x10 is outstanding (k=3)
        check_val("redir_inflight", acc_q[$], 32'h10);
        haz_v = 1'b1; rpc_v = 32'h100;
        cycle();
        haz_v = 1'b0;
        cycle();
        check_val("redir_valid", if_valid, 32'd0);
        check_val("redir_drop_req", req_s, 32'd0);
        cycle(); cycle();
        check_val("redir_req", req_s, 32'd1);
        check_val("redir_addr", addr_s, 32'h100);
        mem_lat = 1;
        wait_consume("redir", 32'h100);

        // redirect with stop, output (and skid) full, unaligned target
        check_val("edge_inflight", acc_q[$], 32'h104);
        stop_v = 1'b1;
        acc0 = acc_q.size();
        repeat (4) cycle();
        check_val("edge_hold_valid", if_valid, 32'd1);
        check_val("edge_hold_pc", if_pc, 32'h104);
        check_val("edge_accepts", acc_q.size() - acc0, EXP_SKID);
        haz_v = 1'b1; rpc_v = 32'h203;
        cycle();
        haz_v = 1'b0; stop_v = 1'b0;
        cycle();
        check_val("edge_flush", if_valid, 32'd0);
        check_val("edge_req", req_s, 32'd1);
        check_val("edge_addr", addr_s, 32'h200);
        wait_consume("edge", 32'h200);

        // wrap target held under imem backpressure
        haz_v = 1'b1; rpc_v = 32'hFFFF_FFFC; rdy_v = 1'b0;
        cycle();
        haz_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("bp_req", req_s, 32'd1);
            check_val("bp_addr", addr_s, 32'hFFFF_FFFC);
        end
        rdy_v = 1'b1; mem_lat = 3;
        wait_consume("wrap", 32'hFFFF_FFFC);
        check_val("wrap_pc4", if_pc4, 32'h0);
        check_val("wrap_next", acc_q[$], 32'h0);

        // asynchronous reset in the middle of WAIT
        cycle();
        #2;
        rst = 1'b1; rst_v = 1'b1; mem_pend = 1'b0;
        #1;
        check_val("mr_req", imem_req, 32'd0);
        check_val("mr_addr", imem_addr, 32'h0);
        check_val("mr_valid", if_valid, 32'd0);
        check_val("mr_pc", if_pc, 32'h0);
        check_val("mr_pc4", if_pc4, 32'h0);
        check_val("mr_inst", if_inst, 32'h0);
        cycle();
        mem_lat = 1; rst_v = 1'b0;
        cycle();
        check_val("mr_start_req", req_s, 32'd1);
        check_val("mr_start_addr", addr_s, 32'h0);
        wait_consume("mr0", 32'h0);
        wait_consume("mr1", 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
